// File: rtl/simple_gmii_pkg.sv
// ---------------------------------------------------------------------------
// simple_gmii_pkg
// Shared definitions for the simple GMII peripheral: transmit FSM state
// encoding, Ethernet framing constants and the byte-wise reflected CRC-32
// update used by both the tx engine and the future rx block.
// ---------------------------------------------------------------------------
package simple_gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned PRE_LEN = 7;
    localparam int unsigned FCS_LEN = 4;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ (c[0] ? CRC_POLY : 32'h00000000);
        end
        return c;
    endfunction

endpackage

// File: rtl/simple_gmii_tx_fifo.sv
// ---------------------------------------------------------------------------
// simple_gmii_tx_fifo
// Synchronous byte FIFO with first-word fall-through read data.
// A push and a pop in the same cycle are both honoured, even when full.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (empties FIFO)
//   wr_data, push    byte to store and its write request
//   pop              consume the byte presented on rd_data
//   rd_data          byte at the head of the FIFO
//   count            bytes currently stored (0 .. 2**AW)
//   full, empty      occupancy flags
// ---------------------------------------------------------------------------
module simple_gmii_tx_fifo #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          push,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // When full, a simultaneous pop frees the slot being written this cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simple_gmii_tx.sv
// ---------------------------------------------------------------------------
// simple_gmii_tx
// GMII transmit engine. Buffers bytes from the register block and, on a
// start request, sends one Ethernet frame: 7x preamble, SFD, payload,
// zero padding up to MIN_LEN, FCS (LSB first), then an inter-frame gap.
// Ports:
//   clk, reset     125 MHz GMII tx clock, asynchronous active-high reset
//   tx_data        byte from the register block
//   tx_data_stb    one-cycle push strobe for tx_data
//   tx_start       start request level (held until cleared)
//   tx_start_clr   one-cycle pulse clearing tx_start in the register block
//   status_set     one-cycle pulses: [0] frame done, [1] overflow/empty start
//   gmii_txd       GMII transmit data (0 while gmii_tx_en is low)
//   gmii_tx_en     GMII transmit enable
//   gmii_tx_er     GMII transmit error, always 0
// ---------------------------------------------------------------------------
module simple_gmii_tx
    import simple_gmii_pkg::*;
#(
    parameter int unsigned FIFO_AW = 11,
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned IFG_CYC = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_data_stb,
    input  logic       tx_start,
    output logic       tx_start_clr,
    output logic [1:0] status_set,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er
);

    localparam int unsigned CW = FIFO_AW + 1;

    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] PRE_LAST_C = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] MIN_LEN_C  = CW'(MIN_LEN);
    localparam logic [CW-1:0] FCS_LEN_C  = CW'(FCS_LEN);
    localparam logic [CW-1:0] IFG_LAST_C = CW'(IFG_CYC - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] frame_len;
    logic [31:0]   crc;
    logic [31:0]   crc_inv;

    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_overflow;

    assign gmii_tx_er = 1'b0;
    assign crc_inv    = ~crc;

    simple_gmii_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data (tx_data),
        .push    (tx_data_stb),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The byte registered onto gmii_txd at the next edge is popped in the
    // same cycle, so the FIFO head is consumed while leaving SFD and while
    // DATA still has payload left.
    always_comb begin
        fifo_pop = 1'b0;
        if (state == ST_SFD) begin
            fifo_pop = 1'b1;
        end else if (state == ST_DATA && cnt != frame_len) begin
            fifo_pop = 1'b1;
        end
    end

    assign fifo_overflow = tx_data_stb && fifo_full && !fifo_pop;

    // The state register names the segment currently on the wire; each
    // transition registers the first byte of the segment being entered.
    // The CRC is advanced on the same edge a DATA/PAD byte is registered,
    // so on entry to FCS it already covers every byte sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            frame_len    <= '0;
            crc          <= CRC_INIT;
            gmii_txd     <= '0;
            gmii_tx_en   <= 1'b0;
            tx_start_clr <= 1'b0;
            status_set   <= '0;
        end else begin
            tx_start_clr <= 1'b0;
            status_set   <= {fifo_overflow, 1'b0};

            unique case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        if (fifo_empty) begin
                            tx_start_clr  <= 1'b1;
                            status_set[1] <= 1'b1;
                        end else begin
                            frame_len  <= fifo_count;
                            crc        <= CRC_INIT;
                            cnt        <= '0;
                            gmii_tx_en <= 1'b1;
                            gmii_txd   <= PREAMBLE;
                            state      <= ST_PRE;
                        end
                    end
                end

                ST_PRE: begin
                    if (cnt == PRE_LAST_C) begin
                        gmii_txd <= SFD;
                        state    <= ST_SFD;
                    end else begin
                        cnt      <= cnt + ONE_C;
                        gmii_txd <= PREAMBLE;
                    end
                end

                ST_SFD: begin
                    gmii_txd <= fifo_rd_data;
                    crc      <= crc32_byte(crc, fifo_rd_data);
                    cnt      <= ONE_C;
                    state    <= ST_DATA;
                end

                ST_DATA: begin
                    if (cnt != frame_len) begin
                        gmii_txd <= fifo_rd_data;
                        crc      <= crc32_byte(crc, fifo_rd_data);
                        cnt      <= cnt + ONE_C;
                    end else if (cnt < MIN_LEN_C) begin
                        gmii_txd <= '0;
                        crc      <= crc32_byte(crc, 8'h00);
                        cnt      <= cnt + ONE_C;
                        state    <= ST_PAD;
                    end else begin
                        gmii_txd <= crc_inv[7:0];
                        cnt      <= ONE_C;
                        state    <= ST_FCS;
                    end
                end

                ST_PAD: begin
                    if (cnt != MIN_LEN_C) begin
                        gmii_txd <= '0;
                        crc      <= crc32_byte(crc, 8'h00);
                        cnt      <= cnt + ONE_C;
                    end else begin
                        gmii_txd <= crc_inv[7:0];
                        cnt      <= ONE_C;
                        state    <= ST_FCS;
                    end
                end

                ST_FCS: begin
                    if (cnt == FCS_LEN_C) begin
                        gmii_tx_en    <= 1'b0;
                        gmii_txd      <= '0;
                        tx_start_clr  <= 1'b1;
                        status_set[0] <= 1'b1;
                        cnt           <= ONE_C;
                        state         <= ST_IFG;
                    end else begin
                        gmii_txd <= crc_inv[{cnt[1:0], 3'b000} +: 8];
                        cnt      <= cnt + ONE_C;
                    end
                end

                // The IDLE cycle that samples tx_start is also low, so IFG
                // itself lasts one cycle less than the full gap.
                ST_IFG: begin
                    if (cnt >= IFG_LAST_C) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                default: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= '0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_gmii_tx.sv
module tb_simple_gmii_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_data_stb;
    logic       tx_start;
    logic       tx_start_clr;
    logic [1:0] status_set;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    always #4 clk = ~clk;

    simple_gmii_tx #(
        .FIFO_AW (11),
        .MIN_LEN (60),
        .IFG_CYC (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_data_stb  (tx_data_stb),
        .tx_start     (tx_start),
        .tx_start_clr (tx_start_clr),
        .status_set   (status_set),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er)
    );

    int tests = 0;
    int fails = 0;

    // scoreboard state
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    bit          in_frame = 1'b0;
    bit          aborting = 1'b0;
    int          run = 0;
    int          low_cnt = 0;
    int          last_gap = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] mon_crc = 32'hFFFFFFFF;

    logic [7:0]  pl[$];

    // bit-serial reflected CRC-32 reference
    function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ d[j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired before the DUT responded", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue_frame(input logic [7:0] p[$]);
        logic [31:0] c;
        logic [7:0]  b;
        int          n;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        n = (p.size() < 60) ? 60 : p.size();
        for (int i = 0; i < n; i++) begin
            b = (i < p.size()) ? p[i] : 8'h00;
            exp_q.push_back(b);
            c = model_crc(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        exp_len_q.push_back(8 + n + 4);
    endtask

    task automatic push_bytes(input logic [7:0] p[$]);
        tx_data_stb = 1'b1;
        foreach (p[i]) begin
            tx_data = p[i];
            tick();
        end
        tx_data_stb = 1'b0;
    endtask

    task automatic start_frame(input string name);
        tx_start = 1'b1;
        tick();
        check(name, {31'd0, gmii_tx_en}, 32'd1);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames_done(input int budget);
        int t;
        t = 0;
        while ((exp_len_q.size() != 0 || in_frame) && t < budget) begin
            tick();
            t++;
        end
        if (t >= budget) begin
            timeout_fail("frame_timeout");
            exp_q.delete();
            exp_len_q.delete();
        end
        repeat (14) tick();
    endtask

    // monitor: compares every byte on the wire against the scoreboard
    always @(negedge clk) begin
        if (reset || aborting) begin
            in_frame = 1'b0;
            run      = 0;
            low_cnt  = 0;
        end else begin
            if (gmii_tx_en) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    run      = 0;
                    last_gap = low_cnt;
                    mon_crc  = 32'hFFFFFFFF;
                end
                run++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h, expected no transmission", gmii_txd);
                end else begin
                    check("txd", {24'd0, gmii_txd}, {24'd0, exp_q.pop_front()});
                end
                if (run > 8) mon_crc = model_crc(mon_crc, gmii_txd);
            end else if (in_frame) begin
                in_frame = 1'b0;
                low_cnt  = 1;
                if (exp_len_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got length %0d, expected no frame", run);
                end else begin
                    check("frame_len", run, exp_len_q.pop_front());
                end
                check("crc_residue", mon_crc, 32'hDEBB20E3);
                check("done_pulse", {29'd0, tx_start_clr, status_set}, 32'h5);
                check("txd_idle", {24'd0, gmii_txd}, 32'd0);
            end else begin
                low_cnt++;
            end
            if (status_set[0]) done_cnt++;
            if (status_set[1]) err_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        int t;
        bit rose;

        reset       = 1'b1;
        tx_data     = 8'h00;
        tx_data_stb = 1'b0;
        tx_start    = 1'b0;
        repeat (3) tick();
        check("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
        check("rst_txd", {24'd0, gmii_txd}, 32'd0);
        check("rst_status", {30'd0, status_set}, 32'd0);
        check("rst_clr", {31'd0, tx_start_clr}, 32'd0);
        check("rst_tx_er", {31'd0, gmii_tx_er}, 32'd0);
        reset = 1'b0;
        tick();

        // 60-byte frame, no padding
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        enqueue_frame(pl);
        push_bytes(pl);
        d0 = done_cnt;
        start_frame("t1_latency");
        wait_frames_done(200);
        check("t1_done_count", done_cnt, d0 + 1);

        // single byte, padded to 60
        pl.delete();
        pl.push_back(8'hAA);
        enqueue_frame(pl);
        push_bytes(pl);
        d0 = done_cnt;
        start_frame("t2_latency");
        wait_frames_done(200);
        check("t2_done_count", done_cnt, d0 + 1);

        // start with empty FIFO
        e0 = err_cnt;
        d0 = done_cnt;
        tx_start = 1'b1;
        tick();
        check("t3_clr_pulse", {31'd0, tx_start_clr}, 32'd1);
        check("t3_status", {30'd0, status_set}, 32'd2);
        tx_start = 1'b0;
        tick();
        check("t3_clr_single", {29'd0, tx_start_clr, status_set}, 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (gmii_tx_en) rose = 1'b1;
            tick();
        end
        check("t3_no_tx", {31'd0, rose}, 32'd0);
        check("t3_err_count", err_cnt, e0 + 1);
        check("t3_done_count", done_cnt, d0);

        // overflow: 2049 pushes into a 2048-byte FIFO
        e0 = err_cnt;
        pl.delete();
        for (int i = 0; i < 2048; i++) pl.push_back(8'(i));
        enqueue_frame(pl);
        tx_data_stb = 1'b1;
        for (int i = 0; i < 2049; i++) begin
            tx_data = 8'(i);
            tick();
            if (i == 2047) check("t4_no_err_at_full", {31'd0, status_set[1]}, 32'd0);
            if (i == 2048) check("t4_err_after_2049", {31'd0, status_set[1]}, 32'd1);
        end
        tx_data_stb = 1'b0;
        tick();
        check("t4_err_count", err_cnt, e0 + 1);
        d0 = done_cnt;
        start_frame("t4_latency");
        wait_frames_done(2300);
        check("t4_done_count", done_cnt, d0 + 1);

        // two back-to-back frames with tx_start held
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i * 3));
        enqueue_frame(pl);
        push_bytes(pl);
        d0 = done_cnt;
        tx_start = 1'b1;
        tick();
        check("t5_latency", {31'd0, gmii_tx_en}, 32'd1);
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i) ^ 8'h5A);
        enqueue_frame(pl);
        push_bytes(pl);
        t = 0;
        while (done_cnt < d0 + 1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) timeout_fail("t5_first_done");
        t = 0;
        while (!gmii_tx_en && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) timeout_fail("t5_second_start");
        tx_start = 1'b0;
        tick();
        check("t5_gap", last_gap, 12);
        wait_frames_done(300);
        check("t5_done_count", done_cnt, d0 + 2);

        // reset in the middle of DATA byte 20
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i + 7));
        enqueue_frame(pl);
        push_bytes(pl);
        d0 = done_cnt;
        start_frame("t6_latency");
        repeat (28) tick();
        aborting = 1'b1;
        reset    = 1'b1;
        #1;
        check("t6_async_drop", {31'd0, gmii_tx_en}, 32'd0);
        check("t6_async_txd", {24'd0, gmii_txd}, 32'd0);
        exp_q.delete();
        exp_len_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        aborting = 1'b0;
        tick();
        check("t6_no_done", done_cnt, d0);
        tx_start = 1'b1;
        tick();
        check("t6_fifo_empty", {29'd0, tx_start_clr, status_set}, 32'h6);
        check("t6_no_tx", {31'd0, gmii_tx_en}, 32'd0);
        tx_start = 1'b0;
        tick();
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i) ^ 8'hC3);
        enqueue_frame(pl);
        push_bytes(pl);
        d0 = done_cnt;
        start_frame("t6b_latency");
        wait_frames_done(200);
        check("t6b_done_count", done_cnt, d0 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
